// File: rtl/foo_pkg.sv
// Shared constants and helpers for the foo lane-event collector.
package foo_pkg;

  localparam int FOO_MAX_LANES = 32;

  function automatic int lane_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Adds inc to cur and clamps at 2^w-1 (w up to 32).
  function automatic logic [31:0] sat_add(logic [31:0] cur, logic [31:0] inc, int w);
    logic [32:0] sum;
    logic [32:0] max;
    max = (33'd1 << w) - 33'd1;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/foo_intf.sv
// Single-bit lane interface; producers use source, consumers use sink.
interface foo_intf;
  logic a;

  modport source (output a);
  modport sink   (input  a);
endinterface

// File: rtl/foo_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module foo_rr_pick #(
  parameter int N      = 4,
  parameter int LANE_W = 2
) (
  input  logic [N-1:0]      req,
  input  logic [LANE_W-1:0] ptr,
  output logic              any,
  output logic [LANE_W-1:0] idx
);

  function automatic int wrap(int v);
    return (v >= N) ? v - N : v;
  endfunction

  // Scan offsets from the far end so the closest-to-ptr request wins last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap(int'(ptr) + k)]) begin
        any = 1'b1;
        idx = LANE_W'(wrap(int'(ptr) + k));
      end
    end
  end

endmodule

// File: rtl/foo_sink_collector.sv
// Watches each lane of a foo_intf array for rising edges and drains one pending
// event per cycle, round-robin, through a valid/ready port with saturating counters.
module foo_sink_collector
  import foo_pkg::*;
#(
  parameter int  N      = 4,
  parameter int  CNT_W  = 16,
  localparam int LANE_W = lane_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  foo_intf.sink             foos [N-1:0],
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [LANE_W-1:0] evt_lane,
  output logic [N-1:0]      level,
  output logic [CNT_W-1:0]  evt_count,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [N-1:0]      a_vec;
  logic [N-1:0]      level_q, pending_q, pending_d;
  logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              evt_valid_q, evt_valid_d;
  logic [LANE_W-1:0] evt_lane_q, evt_lane_d;
  logic [CNT_W-1:0]  evt_count_q, evt_count_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [N-1:0]      rise, clear, drops;
  logic              load, pick_any;
  logic [LANE_W-1:0] pick_idx;
  logic [LANE_W:0]   nxt_ptr;
  logic [31:0]       drop_n;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign a_vec[gi] = foos[gi].a;
  end

  foo_rr_pick #(.N(N), .LANE_W(LANE_W)) u_pick (
    .req (pending_q),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    rise    = a_vec & ~level_q;
    load    = ~evt_valid_q | evt_ready;
    clear   = (load && pick_any) ? (N'(1) << pick_idx) : '0;
    // A lane being loaded this cycle has room for a fresh edge, so it is not a drop.
    drops   = rise & pending_q & ~clear;
    pending_d = (pending_q & ~clear) | rise;

    drop_n = '0;
    for (int l = 0; l < N; l++) begin
      drop_n = drop_n + 32'(drops[l]);
    end
    drop_cnt_d = CNT_W'(sat_add(32'(drop_cnt_q), drop_n, CNT_W));

    evt_count_d = evt_count_q;
    if (evt_valid_q && evt_ready) begin
      evt_count_d = CNT_W'(sat_add(32'(evt_count_q), 32'd1, CNT_W));
    end

    nxt_ptr     = {1'b0, pick_idx} + (LANE_W + 1)'(1);
    evt_valid_d = evt_valid_q;
    evt_lane_d  = evt_lane_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      evt_valid_d = pick_any;
      if (pick_any) begin
        evt_lane_d = pick_idx;
        rr_ptr_d   = (nxt_ptr == (LANE_W + 1)'(N)) ? '0 : nxt_ptr[LANE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_lane_q  <= '0;
      evt_count_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      level_q     <= a_vec;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_lane_q  <= evt_lane_d;
      evt_count_q <= evt_count_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_lane  = evt_lane_q;
  assign level     = level_q;
  assign evt_count = evt_count_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_foo_sink_collector.sv
// Directed checks of foo_sink_collector with four lanes and a 4-bit counter width.
module tb_foo_sink_collector;
  localparam int N = 4;
  localparam int CNT_W = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          evt_ready = 1'b0;
  logic [N-1:0]  lanes = '0;
  logic          evt_valid;
  logic [LW-1:0] evt_lane;
  logic [N-1:0]  level;
  logic [CNT_W-1:0] evt_count, drop_cnt;

  int checks = 0;
  int errors = 0;
  int ev_tot = 0;
  int ev_lane [N];

  foo_intf foos_if [N-1:0] ();

  for (genvar gi = 0; gi < N; gi++) begin : g_drv
    assign foos_if[gi].a = lanes[gi];
  end

  foo_sink_collector #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .foos      (foos_if),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_lane  (evt_lane),
    .level     (level),
    .evt_count (evt_count),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step and tally the event presented (accepted on the next edge when ready=1).
  task automatic step_obs();
    step();
    if (evt_valid && evt_ready) begin
      ev_tot++;
      ev_lane[evt_lane]++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lanes = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic clr_obs();
    ev_tot = 0;
    for (int i = 0; i < N; i++) ev_lane[i] = 0;
  endtask

  initial begin
    // Reset with arbitrary lane values.
    rst = 1'b1;
    lanes = 4'b1011;
    evt_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_lane", 32'(evt_lane), 0);
    check("rst_level", 32'(level), 0);
    check("rst_count", 32'(evt_count), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    lanes = '0;
    rst = 1'b0;
    step();
    step();
    step();
    check("idle_valid", 32'(evt_valid), 0);

    // Single edge on lane 2.
    lanes = 4'b0100;
    step();
    check("single_k_valid", 32'(evt_valid), 0);
    check("single_level", 32'(level), 32'h4);
    step();
    check("single_valid", 32'(evt_valid), 1);
    check("single_lane", 32'(evt_lane), 2);
    step();
    check("single_done", 32'(evt_valid), 0);
    check("single_count", 32'(evt_count), 1);
    check("single_drop", 32'(drop_cnt), 0);

    // Four simultaneous edges from rr_ptr=0.
    do_reset();
    lanes = 4'b1111;
    step();
    for (int i = 0; i < N; i++) begin
      step();
      check($sformatf("simul_valid%0d", i), 32'(evt_valid), 1);
      check($sformatf("simul_lane%0d", i), 32'(evt_lane), 32'(i));
    end
    step();
    check("simul_done", 32'(evt_valid), 0);
    check("simul_count", 32'(evt_count), 4);

    // Backpressure: held event, one pending, one drop.
    do_reset();
    evt_ready = 1'b0;
    lanes = 4'b0010;
    step();
    step();
    check("bp_valid", 32'(evt_valid), 1);
    check("bp_lane", 32'(evt_lane), 1);
    for (int r = 0; r < 2; r++) begin
      lanes = 4'b0000;
      step();
      lanes = 4'b0010;
      step();
      check($sformatf("bp_hold_valid%0d", r), 32'(evt_valid), 1);
      check($sformatf("bp_hold_lane%0d", r), 32'(evt_lane), 1);
    end
    check("bp_drop", 32'(drop_cnt), 1);
    check("bp_count0", 32'(evt_count), 0);
    evt_ready = 1'b1;
    step();
    check("bp_second_valid", 32'(evt_valid), 1);
    check("bp_second_lane", 32'(evt_lane), 1);
    check("bp_count1", 32'(evt_count), 1);
    step();
    check("bp_done", 32'(evt_valid), 0);
    check("bp_count2", 32'(evt_count), 2);

    // Binary count stimulus on the lanes.
    do_reset();
    clr_obs();
    for (int v = 0; v < 16; v++) begin
      lanes = 4'(v);
      step_obs();
    end
    for (int c = 0; c < 10; c++) step_obs();
    check("bin_events", 32'(ev_tot), 15);
    check("bin_lane0", 32'(ev_lane[0]), 8);
    check("bin_lane1", 32'(ev_lane[1]), 4);
    check("bin_lane2", 32'(ev_lane[2]), 2);
    check("bin_lane3", 32'(ev_lane[3]), 1);
    check("bin_count", 32'(evt_count), 15);
    check("bin_drop", 32'(drop_cnt), 0);

    // Saturation: 20 accepted events into a 4-bit counter.
    do_reset();
    clr_obs();
    for (int t = 0; t < 20; t++) begin
      lanes = 4'b0001;
      step_obs();
      lanes = 4'b0000;
      step_obs();
    end
    for (int c = 0; c < 5; c++) step_obs();
    check("sat_events", 32'(ev_tot), 20);
    check("sat_count", 32'(evt_count), 15);
    check("sat_drop", 32'(drop_cnt), 0);

    // Async reset mid-cycle while an event is held.
    evt_ready = 1'b0;
    lanes = 4'b0100;
    step();
    step();
    check("ar_held_valid", 32'(evt_valid), 1);
    #2;
    rst = 1'b1;
    lanes = 4'b0001;
    #1;
    check("ar_valid", 32'(evt_valid), 0);
    check("ar_lane", 32'(evt_lane), 0);
    check("ar_count", 32'(evt_count), 0);
    check("ar_level", 32'(level), 0);
    step();
    evt_ready = 1'b1;
    rst = 1'b0;
    clr_obs();
    for (int c = 0; c < 10; c++) step_obs();
    check("ar_events", 32'(ev_tot), 1);
    check("ar_lane0", 32'(ev_lane[0]), 1);
    check("ar_count1", 32'(evt_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
